// File: rtl/timer_set_pkg.sv
// Shared constants for the timer_set bank and its down-counter.
package timer_set_pkg;

    localparam int TIMER_W = 8;

endpackage

// File: rtl/timer_count.sv
// Loadable down counter that stops at zero and exposes zero and one flags.
module timer_count
    import timer_set_pkg::*;
#(
    parameter int W = TIMER_W
) (
    input  logic         clock,
    input  logic         reset,
    input  logic [W-1:0] preset,
    input  logic         load,
    input  logic [W-1:0] load_value,
    input  logic         run,
    output logic [W-1:0] cnt,
    output logic         zero,
    output logic         one
);

    // A load always wins; otherwise count down only while enabled and not yet at zero.
    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            cnt <= preset;
        end else if (load) begin
            cnt <= load_value;
        end else if (run && (cnt != '0)) begin
            cnt <= cnt - 1'b1;
        end
    end

    assign zero = (cnt == '0);
    assign one  = (cnt == W'(1));

endmodule

// File: rtl/timer_set.sv
// Three software-loaded timers: one-shot alarm (bell), busy gate (act) and periodic strobe (beep).
module timer_set
    import timer_set_pkg::*;
#(
    parameter int W = TIMER_W
) (
    input  logic         clock,
    input  logic         reset,
    input  logic [W-1:0] init,
    input  logic [W-1:0] value,
    input  logic         put,
    output logic         bell,
    output logic         act,
    output logic         beep
);

    logic [W-1:0] alarm_cnt, pulse_cnt, strobe_cnt;
    logic         alarm_zero, alarm_one;
    logic         pulse_zero, pulse_one;
    logic         strobe_zero, strobe_one;
    logic [W-1:0] per;
    logic         strobe_on;
    logic         strobe_load;
    logic [W-1:0] strobe_value;

    timer_count #(.W(W)) u_alarm (
        .clock      (clock),
        .reset      (reset),
        .preset     (init),
        .load       (put),
        .load_value (value),
        .run        (1'b1),
        .cnt        (alarm_cnt),
        .zero       (alarm_zero),
        .one        (alarm_one)
    );

    timer_count #(.W(W)) u_pulse (
        .clock      (clock),
        .reset      (reset),
        .preset     (init),
        .load       (put),
        .load_value (value),
        .run        (1'b1),
        .cnt        (pulse_cnt),
        .zero       (pulse_zero),
        .one        (pulse_one)
    );

    // The strobe counter reloads from the period on reaching zero; a zero period parks it.
    assign strobe_on    = (per != '0);
    assign strobe_load  = put || (strobe_on && strobe_zero);
    assign strobe_value = put ? value : per;

    timer_count #(.W(W)) u_strobe (
        .clock      (clock),
        .reset      (reset),
        .preset     (init),
        .load       (strobe_load),
        .load_value (strobe_value),
        .run        (strobe_on),
        .cnt        (strobe_cnt),
        .zero       (strobe_zero),
        .one        (strobe_one)
    );

    // A put discards any bell or beep that the old count would have produced.
    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            per  <= init;
            bell <= 1'b0;
            beep <= 1'b0;
        end else begin
            if (put) begin
                per <= value;
            end
            bell <= !put && alarm_one;
            beep <= !put && strobe_on && strobe_zero;
        end
    end

    assign act = !pulse_zero;

    logic unused_flags;
    assign unused_flags = &{1'b0, alarm_zero, pulse_one, strobe_one, alarm_cnt, pulse_cnt, strobe_cnt};

endmodule

// File: tb/tb_timer_set.sv
// Self-checking bench for timer_set: directed scenarios followed by random loads against an elapsed-time model.
module tb_timer_set;

    localparam int W = 8;

    logic         clock = 1'b0;
    logic         reset = 1'b0;
    logic [W-1:0] init  = '0;
    logic [W-1:0] value = '0;
    logic         put   = 1'b0;
    logic         bell;
    logic         act;
    logic         beep;

    int checks = 0;
    int errors = 0;

    // Model: edges since the last load (or reset release) and the value loaded then.
    int since  = 0;
    int load_v = 0;

    always #5 clock = ~clock;

    timer_set #(.W(W)) dut (
        .clock (clock),
        .reset (reset),
        .init  (init),
        .value (value),
        .put   (put),
        .bell  (bell),
        .act   (act),
        .beep  (beep)
    );

    task automatic compare(input string tag, input logic observed, input logic expected);
        checks++;
        assert (observed === expected)
        else begin
            errors++;
            $error("FAIL %s t=%0t since=%0d load=%0d observed=%0b expected=%0b",
                   tag, $time, since, load_v, observed, expected);
        end
    endtask

    task automatic checkOutput(input string tag);
        logic exp_bell, exp_act, exp_beep;
        exp_act  = (since < load_v);
        exp_bell = (load_v != 0) && (since == load_v);
        exp_beep = (load_v != 0) && (since >= load_v + 1) &&
                   (((since - load_v - 1) % (load_v + 1)) == 0);
        compare({tag, ".bell"}, bell, exp_bell);
        compare({tag, ".act"},  act,  exp_act);
        compare({tag, ".beep"}, beep, exp_beep);
    endtask

    // Called just after a check (1ns past an edge); drives inputs and advances one edge per cycle.
    task automatic applyStimulus(input string tag, input logic p, input logic [W-1:0] v, input int cycles);
        for (int c = 0; c < cycles; c++) begin
            put   = p;
            value = v;
            @(posedge clock);
            if (p) begin
                since  = 0;
                load_v = int'(v);
            end else begin
                since++;
            end
            #1;
            checkOutput(tag);
        end
        put = 1'b0;
    endtask

    task automatic doReset(input string tag, input logic [W-1:0] new_init);
        #2;
        put    = 1'b0;
        init   = new_init;
        reset  = 1'b0;
        since  = 0;
        load_v = int'(new_init);
        #1;
        checkOutput({tag, ".async"});
        repeat (2) @(posedge clock);
        #1;
        checkOutput({tag, ".held"});
        #2;
        reset = 1'b1;
        #1;
    endtask

    initial begin
        logic         rp;
        logic [W-1:0] rv;

        // Power-up reset with init = 0: everything idle, strobe disabled.
        #1;
        checkOutput("por");
        #2;
        reset = 1'b1;
        applyStimulus("idle0", 1'b0, 8'h00, 20);

        // Single load of 0x11: act 17 cycles, bell, then beeps every 18.
        applyStimulus("load11", 1'b1, 8'h11, 1);
        applyStimulus("run11", 1'b0, 8'h00, 45);

        // Retrigger three cycles after the first load.
        applyStimulus("retrig_a", 1'b1, 8'h11, 1);
        applyStimulus("retrig_b", 1'b0, 8'h00, 3);
        applyStimulus("retrig_c", 1'b1, 8'h11, 1);
        applyStimulus("retrig_d", 1'b0, 8'h00, 40);

        // Reset preset of 5: bell at edge 5, beep every 6 from edge 6.
        doReset("rst5", 8'h05);
        applyStimulus("init5", 1'b0, 8'h00, 25);

        // Loading zero mid-count cancels every channel.
        applyStimulus("cancel_a", 1'b1, 8'h11, 1);
        applyStimulus("cancel_b", 1'b0, 8'h00, 6);
        applyStimulus("cancel_c", 1'b1, 8'h00, 1);
        applyStimulus("cancel_d", 1'b0, 8'h00, 25);

        // Held put keeps reloading; counting starts when it drops.
        applyStimulus("hold_a", 1'b1, 8'h03, 4);
        applyStimulus("hold_b", 1'b0, 8'h00, 12);

        // Value 1 boundary: act one cycle, bell next, beep every 2.
        applyStimulus("one_a", 1'b1, 8'h01, 1);
        applyStimulus("one_b", 1'b0, 8'h00, 8);

        // Reset with a bell pending, then release with init 0.
        applyStimulus("pend_a", 1'b1, 8'h07, 1);
        applyStimulus("pend_b", 1'b0, 8'h00, 6);
        doReset("rst0", 8'h00);
        applyStimulus("pend_c", 1'b0, 8'h00, 15);

        // Random loads with mostly small values so expiries and wraps are frequent.
        for (int i = 0; i < 400; i++) begin
            rp = ($urandom_range(0, 7) == 0);
            if ($urandom_range(0, 4) == 0)
                rv = W'($urandom_range(0, 255));
            else
                rv = W'($urandom_range(0, 6));
            applyStimulus("rand", rp, rv, 1);
            if (i == 200) begin
                doReset("rst_rand", W'($urandom_range(1, 9)));
            end
        end

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
